cascade_counter_updn: RTL and testbench
=======================================

# cascade_counter_updn

Parametrised two-stage cascaded counter: a low stage `qa` and a high stage `qb` with independent moduli, synchronous parallel load, count enable, up/down direction, combinational carry/borrow out and a sticky wrap flag. It generalises the fixed 4-bit/3-bit loadable cascade used in the lab timers. Typical uses are mod-60 seconds, mod-24 hours and BCD-digit pairs. Instances chain through `Co` into the next instance's `en`.

## Interface
- `WA`, 4: width of low stage `qa` / `Da`.
- `WB`, 3: width of high stage `qb` / `Db`.
- `MODA`, 10: low-stage modulus. Legal range is 2..2^WA.
- `MODB`, 6: high-stage modulus. Legal range is 2..2^WB.
- `clk` in 1: rising-edge clock; the only clock.
- `clrn` in 1: reset, synchronous, active-high. Sampled on the `clk` rising edge.
- `load` in 1: synchronous parallel load of `Da`/`Db`.
- `en` in 1: count enable.
- `up` in 1: direction. 1 = up, 0 = down.
- `Da` in WA: low-stage load value.
- `Db` in WB: high-stage load value.
- `qa` out WA: low-stage count, registered.
- `qb` out WB: high-stage count, registered.
- `Co` out 1: carry (up) or borrow (down), combinational.
- `wrap` out 1: sticky full-range wrap flag, registered.
- `ld_err` out 1: one-cycle pulse flagging a load value that was clamped, registered.

## Operation
- Priority per edge: `clrn` > `load` > `en`. With none of them active, all registers hold.
- **Reset** (`clrn`=1): `qa`=0, `qb`=0, `wrap`=0, `ld_err`=0.
- **Load** (`load`=1, `clrn`=0):
  - `qa` <= `Da` if `Da` < MODA, else MODA-1.
  - `qb` <= `Db` if `Db` < MODB, else MODB-1.
  - `ld_err` <= 1 if either value was clamped, else 0.
  - `wrap` <= 0.
  - `en` is ignored on this edge.
- **Count up** (`en`=1, `up`=1):
  - If `qa` ≠ MODA-1, `qa` increments.
  - Otherwise `qa` goes to 0 and `qb` advances: it increments, or goes to 0 if `qb` = MODB-1.
- **Count down** (`en`=1, `up`=0):
  - If `qa` ≠ 0, `qa` decrements.
  - Otherwise `qa` goes to MODA-1 and `qb` decrements, or goes to MODB-1 if `qb` = 0.
- **Terminal state** `tc`: up → (`qa`=MODA-1 and `qb`=MODB-1); down → (`qa`=0 and `qb`=0).
- `Co` = `en` & `tc` & ~`load` & ~`clrn`. It is combinational, with no extra latency.
- `wrap` is set on any edge where `Co`=1. It clears only on reset or load.
- `ld_err` is 0 on every edge that is not a load edge.
- Direction change needs no sequencing: `up` is sampled each edge, and `Co`/`tc` follow `up` combinationally.
- Arithmetic is modular per stage with no out-of-range states. `qa` never exceeds MODA-1 and `qb` never exceeds MODB-1.
- When MODA = 2^WA or MODB = 2^WB, the clamp never fires for that stage.

## Timing
- Single clock domain. All state changes on the `clk` rising edge.
- Load latency: 1 edge. `qa`/`qb` show the (clamped) values after the load edge.
- Count latency: 1 edge per step.
- Full cycle: MODA·MODB enabled edges return the count to its start; `Co` is high on exactly one of them.
- `Co` is valid in the same cycle as `tc` and `en`, before the wrapping edge. It drops after the edge unless the count is still terminal.
- `en` low freezes all registers. `Co` is 0 while `en` is low, even at terminal state.
- Reset mid-count: takes effect on the next edge regardless of `load`/`en`. `Co` is forced 0 in the reset cycle.
- Simultaneous `load` and `en` at terminal state: the load wins, `Co`=0 and `wrap` is cleared.
- The `ld_err` pulse is exactly one cycle wide.

## Test plan
All scenarios use default parameters (MODA=10, MODB=6) and a 100 ns clock.
- **Reset:** `clrn`=1 for 2 edges with `load`/`en`=1 → `qa`=0, `qb`=0, `wrap`=0, `Co`=0, `ld_err`=0.
- **Load and count up:**
  - Load `Da`=7, `Db`=5; `ld_err`=0.
  - Then `up`=1, `en`=1 → after 2 edges `qa`=9, `qb`=5, `Co`=1.
  - Next edge → `qa`=0, `qb`=0, `wrap`=1, `Co`=0.
- **Clamp and count down:**
  - Load `Da`=12, `Db`=7 → `qa`=9, `qb`=5; `ld_err`=1 for one cycle, then 0.
  - Load 0/0, then `up`=0, `en`=1 → `Co`=1 immediately.
  - Next edge → `qa`=9, `qb`=5, `wrap`=1.
- **Enable gating:**
  - From `qa`=3, `qb`=2 counting up, drop `en` for 2 edges → values hold at 3/2.
  - At terminal state with `en`=0 → `Co`=0.
  - Re-enable → the count resumes at 4/2.
- **Full period:** from reset, 60 enabled up edges → exactly one `Co` pulse and a return to 0/0. Check every intermediate value against a reference model.
- **Priority:**
  - At 9/5 up with `load`=1, `en`=1, `Da`=2, `Db`=1 → `Co`=0 and the result is 2/1, with `wrap` cleared.
  - `clrn`=1 together with `load`=1 → result 0/0.

Source files
------------

// File: rtl/cascade_counter_updn_if.sv
// ---------------------------------------------------------------------------
// cascade_counter_updn_if
// Bundles the control, load-data and status signals of one cascaded
// up/down counter instance. Clock and reset stay plain ports on the counter.
//
//   load    : synchronous parallel load request
//   en      : count enable (chain from the previous instance's Co)
//   up      : direction, 1 = up, 0 = down
//   Da, Db  : low / high stage load values
//   qa, qb  : low / high stage registered counts
//   Co      : combinational carry (up) or borrow (down)
//   wrap    : sticky full-range wrap flag
//   ld_err  : one-cycle pulse when a load value was clamped
//
// master drives the controls and watches the status; slave is the counter.
// ---------------------------------------------------------------------------
interface cascade_counter_updn_if #(
  parameter int WA = 4,
  parameter int WB = 3
);

  logic          load;
  logic          en;
  logic          up;
  logic [WA-1:0] Da;
  logic [WB-1:0] Db;
  logic [WA-1:0] qa;
  logic [WB-1:0] qb;
  logic          Co;
  logic          wrap;
  logic          ld_err;

  modport master (
    output load, en, up, Da, Db,
    input  qa, qb, Co, wrap, ld_err
  );

  modport slave (
    input  load, en, up, Da, Db,
    output qa, qb, Co, wrap, ld_err
  );

endinterface

// File: rtl/cascade_counter_updn.sv
// ---------------------------------------------------------------------------
// cascade_counter_updn
// Two-stage cascaded modular counter. The low stage qa counts modulo MODA,
// the high stage qb counts modulo MODB and advances only when qa wraps.
// Supports synchronous clamped parallel load, count enable, up/down
// direction, a combinational carry/borrow out and a sticky wrap flag.
//
// Ports:
//   clk   : rising-edge clock
//   clrn  : synchronous active-high reset (highest priority)
//   bus   : slave side of cascade_counter_updn_if
//           (load, en, up, Da, Db in; qa, qb, Co, wrap, ld_err out)
//
// Edge priority: clrn > load > en; with none active everything holds.
// ---------------------------------------------------------------------------
module cascade_counter_updn #(
  parameter int WA   = 4,
  parameter int WB   = 3,
  parameter int MODA = 10,
  parameter int MODB = 6
) (
  input logic clk,
  input logic clrn,
  cascade_counter_updn_if.slave bus
);

  // Top values of each stage, plus the moduli held one bit wider so that a
  // full power-of-two modulus is representable for the load clamp compare.
  localparam logic [WA-1:0] AMAX  = WA'(MODA - 1);
  localparam logic [WB-1:0] BMAX  = WB'(MODB - 1);
  localparam logic [WA:0]   MODAW = (WA + 1)'(MODA);
  localparam logic [WB:0]   MODBW = (WB + 1)'(MODB);

  logic [WA-1:0] qa;
  logic [WB-1:0] qb;
  logic          wrap;
  logic          ld_err;

  logic [WA-1:0] qa_next;
  logic [WB-1:0] qb_next;
  logic [WA-1:0] da_clamped;
  logic [WB-1:0] db_clamped;
  logic          a_clamp;
  logic          b_clamp;
  logic          tc;
  logic          co;

  // Terminal state depends on direction, so Co follows up with no delay.
  always_comb begin
    tc = 1'b0;
    if (bus.up) begin
      tc = (qa == AMAX) && (qb == BMAX);
    end else begin
      tc = (qa == '0) && (qb == '0);
    end
  end

  // Reset and load both suppress the carry in the same cycle.
  assign co = bus.en & tc & ~bus.load & ~clrn;

  // Out-of-range load values saturate to the stage top value.
  always_comb begin
    a_clamp    = !({1'b0, bus.Da} < MODAW);
    b_clamp    = !({1'b0, bus.Db} < MODBW);
    da_clamped = a_clamp ? AMAX : bus.Da;
    db_clamped = b_clamp ? BMAX : bus.Db;
  end

  // One count step. qb only moves when qa passes through its wrap point.
  always_comb begin
    qa_next = qa;
    qb_next = qb;
    if (bus.up) begin
      if (qa != AMAX) begin
        qa_next = qa + WA'(1);
      end else begin
        qa_next = '0;
        qb_next = (qb == BMAX) ? '0 : qb + WB'(1);
      end
    end else begin
      if (qa != '0) begin
        qa_next = qa - WA'(1);
      end else begin
        qa_next = AMAX;
        qb_next = (qb == '0) ? BMAX : qb - WB'(1);
      end
    end
  end

  // State registers. ld_err is rewritten on every non-reset edge so that it
  // can only ever be a single-cycle pulse following a clamped load.
  always_ff @(posedge clk) begin
    if (clrn) begin
      qa     <= '0;
      qb     <= '0;
      wrap   <= 1'b0;
      ld_err <= 1'b0;
    end else if (bus.load) begin
      qa     <= da_clamped;
      qb     <= db_clamped;
      wrap   <= 1'b0;
      ld_err <= a_clamp | b_clamp;
    end else if (bus.en) begin
      qa     <= qa_next;
      qb     <= qb_next;
      ld_err <= 1'b0;
      if (co) begin
        wrap <= 1'b1;
      end
    end else begin
      ld_err <= 1'b0;
    end
  end

  assign bus.qa     = qa;
  assign bus.qb     = qb;
  assign bus.Co     = co;
  assign bus.wrap   = wrap;
  assign bus.ld_err = ld_err;

endmodule

// File: tb/tb_cascade_counter_updn.sv
// ---------------------------------------------------------------------------
// tb_cascade_counter_updn
// Scoreboard bench for cascade_counter_updn with default parameters.
// The driver issues one set of inputs per cycle and pushes the expected
// Co for that cycle together with the expected state after the next edge.
// The monitor pops entries independently and compares against the DUT.
// The reference model treats the pair of stages as a single number
// qb*MODA + qa counting modulo MODA*MODB.
// ---------------------------------------------------------------------------
module tb_cascade_counter_updn;

  localparam int WA   = 4;
  localparam int WB   = 3;
  localparam int MODA = 10;
  localparam int MODB = 6;
  localparam int N    = MODA * MODB;

  typedef struct {
    int co;
    int qa;
    int qb;
    int wrap;
    int lderr;
  } exp_t;

  logic clk;
  logic clrn;

  cascade_counter_updn_if #(.WA(WA), .WB(WB)) bus ();

  cascade_counter_updn #(
    .WA(WA), .WB(WB), .MODA(MODA), .MODB(MODB)
  ) dut (
    .clk (clk),
    .clrn(clrn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_total = 0;
  int m_wrap  = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the DUT must do with them.
  task automatic applyStimulus(input bit c, input bit l, input bit e, input bit u,
                               input int da, input int db);
    exp_t x;
    int   tc;
    int   a;
    int   b;
    @(posedge clk);
    #10;
    clrn     = c;
    bus.load = l;
    bus.en   = e;
    bus.up   = u;
    bus.Da   = WA'(da);
    bus.Db   = WB'(db);

    tc   = u ? (m_total == N - 1) : (m_total == 0);
    x.co = (e && tc && !l && !c) ? 1 : 0;
    x.lderr = 0;
    if (c) begin
      m_total = 0;
      m_wrap  = 0;
    end else if (l) begin
      a       = (da < MODA) ? da : MODA - 1;
      b       = (db < MODB) ? db : MODB - 1;
      x.lderr = (da >= MODA || db >= MODB) ? 1 : 0;
      m_total = b * MODA + a;
      m_wrap  = 0;
    end else if (e) begin
      if (x.co != 0) m_wrap = 1;
      m_total = u ? (m_total + 1) % N : (m_total + N - 1) % N;
    end
    x.qa   = m_total % MODA;
    x.qb   = m_total / MODA;
    x.wrap = m_wrap;
    q.push_back(x);
  endtask

  // Monitor: Co is checked mid-cycle against the popped entry; the state
  // fields of that entry are checked in the following cycle, after the edge.
  initial begin : monitor
    exp_t pend;
    bit   have_pend;
    have_pend = 1'b0;
    forever begin
      @(posedge clk);
      #40;
      if (have_pend) begin
        checkOutput("qa", int'(bus.qa), pend.qa);
        checkOutput("qb", int'(bus.qb), pend.qb);
        checkOutput("wrap", int'(bus.wrap), pend.wrap);
        checkOutput("ld_err", int'(bus.ld_err), pend.lderr);
        have_pend = 1'b0;
      end
      if (q.size() > 0) begin
        pend = q.pop_front();
        checkOutput("Co", int'(bus.Co), pend.co);
        have_pend = 1'b1;
      end
    end
  end

  initial begin : driver
    int da;
    int db;
    clrn     = 1'b1;
    bus.load = 1'b1;
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    bus.Da   = '0;
    bus.Db   = '0;

    // Reset with load/en asserted.
    applyStimulus(1, 1, 1, 1, 5, 3);
    applyStimulus(1, 1, 1, 1, 5, 3);

    // Load and count up through the terminal state.
    applyStimulus(0, 1, 0, 1, 7, 5);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Clamped load, then count down from 0/0.
    applyStimulus(0, 1, 0, 1, 12, 7);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Single-stage clamps.
    applyStimulus(0, 1, 0, 1, 15, 2);
    applyStimulus(0, 1, 0, 1, 4, 6);
    applyStimulus(0, 1, 0, 1, 9, 5);

    // Enable gating.
    applyStimulus(0, 1, 0, 1, 2, 2);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 9, 5);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Full period from reset.
    applyStimulus(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < N; i++) applyStimulus(0, 0, 1, 1, 0, 0);

    // Priority: wrap down to 9/5 (wrap set), then load beats en at terminal.
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 2, 1);
    applyStimulus(0, 1, 1, 1, 8, 4);
    applyStimulus(1, 1, 1, 1, 8, 4);

    // Randomized traffic, mostly counting with occasional loads and resets.
    for (int i = 0; i < 400; i++) begin
      da = int'($urandom_range(0, 15));
      db = int'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0), da, db);
    end
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #45;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d expected=0 entries left", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
